// File: rtl/sort_check_arbiter.sv
// sort_check_arbiter
//   Shares one arraySortCheck engine between NUM_REQ requesters with
//   round-robin arbitration. For the granted requester it runs the engine's
//   go/done handshake (two LOAD cycles with go high, then drops go to start
//   the run) and returns the sorted flag as a one-cycle resp_valid pulse.
//   A watchdog moves the block to a sticky FAULT state if a run never ends.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   req            per-requester request, held until its resp_valid
//   req_base       packed bases, slice i belongs to requester i
//   req_len        packed lengths, slice i belongs to requester i
//   grant          one-hot grant, high from LOAD through RESP
//   resp_valid     one-cycle pulse to the served requester
//   resp_sorted    result, qualified by resp_valid (0 otherwise)
//   engine_go      go input of the engine (low only during RUN)
//   engine_base    base of the granted requester
//   engine_len     length of the granted requester
//   engine_done    engine done
//   engine_sorted  engine sorted result
//   busy           high outside IDLE and FAULT
//   fault          sticky watchdog flag
module sort_check_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int BASE_W  = 3,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BASE_W-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_sorted,
    output logic                      engine_go,
    output logic [BASE_W-1:0]         engine_base,
    output logic [LEN_W-1:0]          engine_len,
    input  logic                      engine_done,
    input  logic                      engine_sorted,
    output logic                      busy,
    output logic                      fault
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP,
        S_FAULT
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   gidx, gidx_n;
    logic               load_cnt, load_cnt_n;
    logic [CNT_W-1:0]   run_cnt, run_cnt_n;
    logic               sorted_q, sorted_n;
    logic               fault_q, fault_n;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               in_svc;

    logic [NUM_REQ-1:0][BASE_W-1:0] base_arr;
    logic [NUM_REQ-1:0][LEN_W-1:0]  len_arr;

    assign base_arr    = req_base;
    assign len_arr     = req_len;
    assign engine_base = base_arr[gidx];
    assign engine_len  = len_arr[gidx];

    // Round-robin pick: scan from rr_ptr upward with wrap. Walking the
    // offsets high-to-low lets the smallest offset overwrite the others.
    always_comb begin
        int               sum;
        logic [IDX_W-1:0] idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = 0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = IDX_W'(sum);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            gidx     <= '0;
            load_cnt <= 1'b0;
            run_cnt  <= '0;
            sorted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            gidx     <= gidx_n;
            load_cnt <= load_cnt_n;
            run_cnt  <= run_cnt_n;
            sorted_q <= sorted_n;
            fault_q  <= fault_n;
        end
    end

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        gidx_n     = gidx;
        load_cnt_n = load_cnt;
        run_cnt_n  = run_cnt;
        sorted_n   = sorted_q;
        fault_n    = fault_q;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    gidx_n     = pick_idx;
                    load_cnt_n = 1'b0;
                    state_n    = S_LOAD;
                end
            end
            S_LOAD: begin
                // First cycle releases the engine from Done/Garbage into
                // Ready, second lets it latch base/len.
                if (load_cnt) begin
                    run_cnt_n = '0;
                    state_n   = S_RUN;
                end else begin
                    load_cnt_n = 1'b1;
                end
            end
            S_RUN: begin
                run_cnt_n = run_cnt + 1'b1;
                // done on the first RUN cycle may be left over from the
                // previous run, so it is not trusted. done beats timeout.
                if (run_cnt != '0 && engine_done) begin
                    sorted_n = engine_sorted;
                    state_n  = S_RESP;
                end else if (run_cnt == RUN_LAST) begin
                    fault_n = 1'b1;
                    state_n = S_FAULT;
                end
            end
            S_RESP: begin
                rr_ptr_n = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                state_n  = S_IDLE;
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign in_svc      = (state == S_LOAD) || (state == S_RUN) || (state == S_RESP);
    assign engine_go   = (state != S_RUN);
    assign busy        = in_svc;
    assign fault       = fault_q;
    assign resp_sorted = (state == S_RESP) && sorted_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign grant[i]      = in_svc && (gidx == IDX_W'(i));
        assign resp_valid[i] = (state == S_RESP) && (gidx == IDX_W'(i));
    end

endmodule

// File: tb/tb_sort_check_arbiter.sv
// Testbench for sort_check_arbiter: directed and random transactions against
// a transaction-level round-robin model plus a simple engine model.
module tb_sort_check_arbiter;

    localparam int N  = 4;
    localparam int BW = 3;
    localparam int LW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*BW-1:0] req_base;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    grant;
    logic [N-1:0]    resp_valid;
    logic            resp_sorted;
    logic            engine_go;
    logic [BW-1:0]   engine_base;
    logic [LW-1:0]   engine_len;
    logic            engine_done;
    logic            engine_sorted;
    logic            busy;
    logic            fault;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    // engine model: done appears on RUN cycle eng_lat-1 (counted from the
    // cycle go drops); optional stale done on RUN cycle 0; hang never finishes
    logic [7:0] eng_cnt = 8'd0;
    logic [7:0] eng_lat = 8'd2;
    logic       eng_hang = 1'b0;
    logic       eng_stale = 1'b0;
    logic       eng_sorted_v = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) eng_cnt <= engine_go ? 8'd0 : eng_cnt + 8'd1;

    assign engine_done   = !engine_go && !eng_hang &&
                           ((eng_cnt == eng_lat - 8'd1) || (eng_stale && eng_cnt == 8'd0));
    assign engine_sorted = eng_sorted_v;

    sort_check_arbiter #(
        .NUM_REQ(N), .IDX_W(2), .BASE_W(BW), .LEN_W(LW), .TIMEOUT(64)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_base(req_base),
        .req_len(req_len), .grant(grant), .resp_valid(resp_valid),
        .resp_sorted(resp_sorted), .engine_go(engine_go),
        .engine_base(engine_base), .engine_len(engine_len),
        .engine_done(engine_done), .engine_sorted(engine_sorted),
        .busy(busy), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, ".grant"}, grant, 0);
        chk({tag, ".resp_valid"}, resp_valid, 0);
        chk({tag, ".resp_sorted"}, resp_sorted, 0);
        chk({tag, ".engine_go"}, engine_go, 1);
        chk({tag, ".busy"}, busy, 0);
    endtask

    // One full service starting from an IDLE negedge; ends on the IDLE
    // negedge after RESP.
    task automatic serve(input logic [N-1:0] rq, input int lat, input bit srt,
                         input bit stale, input bit drop_mid, input bit keep);
        int g;
        int tot;
        g = rr_pick(rq, model_ptr);
        req = rq;
        req_base = 12'($urandom);
        req_len = 16'($urandom);
        eng_lat = 8'(lat);
        eng_sorted_v = srt;
        eng_stale = stale;
        eng_hang = 1'b0;
        tot = 3 + lat;
        for (int c = 1; c <= tot; c++) begin
            @(negedge clock);
            chk("svc.grant", grant, onehot(g));
            chk("svc.engine_go", engine_go, (c > 2 && c <= 2 + lat) ? 0 : 1);
            chk("svc.resp_valid", resp_valid, (c == tot) ? onehot(g) : 0);
            chk("svc.resp_sorted", resp_sorted, (c == tot) ? 32'(srt) : 0);
            chk("svc.busy", busy, 1);
            chk("svc.fault", fault, 0);
            chk("svc.engine_base", engine_base, req_base[g*BW +: BW]);
            chk("svc.engine_len", engine_len, req_len[g*LW +: LW]);
            if (drop_mid && c == 3) req = '0;
        end
        model_ptr = (g + 1) % N;
        if (!keep) req = '0;
        eng_stale = 1'b0;
        @(negedge clock);
        idle_checks("post");
    endtask

    initial begin
        int g;
        reset = 1'b0;
        req = '0;
        req_base = '0;
        req_len = '0;
        #1;
        idle_checks("rst");
        chk("rst.fault", fault, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            idle_checks("idle");
            chk("idle.fault", fault, 0);
        end

        // single requester, 5 RUN cycles, sorted
        serve(4'b0010, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        // all requesting continuously: one grant each per rotation
        for (int i = 0; i < 5; i++)
            serve(4'b1111, 2 + i % 3, 1'(i & 1), 1'b0, 1'b0, 1'b1);
        req = '0;
        // inversion result, stale done, requester drop mid-run
        serve(4'b0001, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        serve(4'b1000, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        serve(4'b0100, 6, 1'b1, 1'b0, 1'b1, 1'b0);
        // random traffic
        for (int i = 0; i < 20; i++)
            serve(4'($urandom_range(1, 15)), $urandom_range(2, 6),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // async reset in the middle of RUN
        serve(4'b0100, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        req = 4'b0100;
        eng_lat = 8'd20;
        repeat (4) @(negedge clock);
        chk("mid.engine_go", engine_go, 0);
        #2 reset = 1'b0;
        #1;
        idle_checks("mid.rst");
        chk("mid.engine_base", engine_base, req_base[0 +: BW]);
        @(negedge clock);
        reset = 1'b1;
        model_ptr = 0;
        serve(4'b1011, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        serve(4'b0001, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        // watchdog: engine never finishes
        req = 4'b0100;
        eng_hang = 1'b1;
        g = rr_pick(req, model_ptr);
        for (int c = 1; c <= 66; c++) begin
            @(negedge clock);
            if (c == 1 || c == 2 || c == 3 || c >= 64) begin
                chk("wd.grant", grant, onehot(g));
                chk("wd.engine_go", engine_go, (c > 2) ? 0 : 1);
                chk("wd.fault", fault, 0);
            end
        end
        @(negedge clock);
        chk("wd.fault_set", fault, 1);
        idle_checks("wd");
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("wd.sticky", fault, 1);
            idle_checks("wd.hold");
        end
        reset = 1'b0;
        #1;
        chk("wd.rst_fault", fault, 0);
        @(negedge clock);
        reset = 1'b1;
        eng_hang = 1'b0;
        model_ptr = 0;
        req = '0;
        @(negedge clock);
        serve(4'b0010, 3, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
